// File: rtl/wb_sram_slave.sv
// Wishbone slave in front of a word-organised SRAM array: classic cycles plus
// incrementing bursts (linear, wrap-4/8/16) with registered ack/err/data.
module wb_sram_slave #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MEM_SIZE_BYTE = 4096
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [DW-1:0] wb_dat_o
);
    localparam int MEM_WORDS = MEM_SIZE_BYTE / 4;
    localparam int CW        = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [MEM_WORDS];

    logic          req_s;
    logic          hs_s;
    logic          mem_we_s;
    logic [AW-3:0] adr_word_s;
    logic          adr_ok_s;
    logic [CW-1:0] wrap_mask_s;
    logic [CW-1:0] cnt_inc_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          lin_ovf_s;
    logic          unused_s;

    assign req_s      = wb_cyc_i & wb_stb_i;
    assign hs_s       = req_s & ack_q;
    assign adr_word_s = wb_adr_i[AW-1:2];
    assign adr_ok_s   = (adr_word_s < (AW-2)'(MEM_WORDS));
    assign unused_s   = ^wb_adr_i[1:0];

    // Burst counter advance: wrap modes only step the low bits inside the wrap window.
    always_comb begin
        case (wb_bte_i)
            2'b01:   wrap_mask_s = CW'(3);
            2'b10:   wrap_mask_s = CW'(7);
            2'b11:   wrap_mask_s = CW'(15);
            default: wrap_mask_s = CW'(0);
        endcase
        cnt_inc_s = cnt_q + CW'(1);
        if (wb_bte_i == 2'b00) begin
            cnt_nxt_s = cnt_inc_s;
        end else begin
            cnt_nxt_s = (cnt_q & ~wrap_mask_s) | (cnt_inc_s & wrap_mask_s);
        end
        lin_ovf_s = (wb_bte_i == 2'b00) && (cnt_q == CW'(MEM_WORDS - 1));
    end

    // Next-state, termination and read-data selection.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        mem_we_s = 1'b0;
        if (!wb_cyc_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s && !adr_ok_s) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (req_s) begin
                        cnt_d   = adr_word_s[CW-1:0];
                        dat_d   = mem[adr_word_s[CW-1:0]];
                        ack_d   = 1'b1;
                        state_d = (wb_cti_i == 3'b010) ? ST_BURST : ST_SINGLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SINGLE: begin
                    mem_we_s = hs_s & wb_we_i;
                    state_d  = ST_IDLE;
                end
                ST_BURST: begin
                    if (hs_s) begin
                        mem_we_s = wb_we_i;
                        if (wb_cti_i != 3'b010) begin
                            state_d = ST_IDLE;
                        end else if (lin_ovf_s) begin
                            // Stepping off the top of memory: the next beat is refused.
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_nxt_s;
                            dat_d = mem[cnt_nxt_s];
                            ack_d = 1'b1;
                        end
                    end else if (req_s) begin
                        // Master resumed after a wait state: re-present the pending beat.
                        dat_d = mem[cnt_q];
                        ack_d = 1'b1;
                    end else begin
                        ack_d = 1'b0;
                    end
                end
                ST_ERR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= {DW{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte-masked array write; deliberately not reset so contents survive a reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_s && !wb_rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[cnt_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

endmodule
